// File: rtl/counter_checker.sv
// -----------------------------------------------------------------------------
// counter_checker
//
// Receive-side checker for the count / even_count / odd_count triple produced
// by the free-running counter. Samples the triple on qualified cycles (en=1),
// locks after a seed plus LOCK_LEN consecutive consistent samples, and once
// locked flags every sample that breaks the counting rules. Also keeps
// saturating tallies of locked-mode errors and verified count wraps.
//
// Ports
//   clk         in   1    clock, all logic on the rising edge
//   rst         in   1    synchronous reset, active-high (priority over en)
//   en          in   1    sample qualifier
//   count       in   CW   observed count
//   even_count  in   EW   observed even_count
//   odd_count   in   OW   observed odd_count
//   locked      out  1    high while the checker is in CHECK
//   err         out  1    one-cycle pulse per mismatching sample while locked
//   err_field   out  3    [0]=count [1]=even_count [2]=odd_count mismatch bits
//                         of the last error, held until the next error
//   err_total   out  16   locked-mode mismatch tally, saturating
//   wrap_total  out  16   verified count wraps (max->0) while locked, saturating
// -----------------------------------------------------------------------------
module counter_checker #(
    parameter int CW       = 5,
    parameter int EW       = 4,
    parameter int OW       = 3,
    parameter int LOCK_LEN = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [CW-1:0] count,
    input  logic [EW-1:0] even_count,
    input  logic [OW-1:0] odd_count,
    output logic          locked,
    output logic          err,
    output logic [2:0]    err_field,
    output logic [15:0]   err_total,
    output logic [15:0]   wrap_total
);

    // Run counter only has to reach LOCK_LEN.
    localparam int RW = (LOCK_LEN < 2) ? 1 : $clog2(LOCK_LEN + 1);

    // Common width used to compare the three fields in one generate loop.
    localparam int FW = (CW >= EW) ? ((CW >= OW) ? CW : OW)
                                   : ((EW >= OW) ? EW : OW);

    localparam logic [CW-1:0] COUNT_MAX = {CW{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEED  = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // State and registered outputs
    // -------------------------------------------------------------------------
    state_t          state_reg,      state_next;
    logic [CW-1:0]   pc_reg,         pc_next;
    logic [EW-1:0]   pe_reg,         pe_next;
    logic [OW-1:0]   po_reg,         po_next;
    logic [RW-1:0]   run_reg,        run_next;
    logic            err_reg,        err_next;
    logic [2:0]      err_field_reg,  err_field_next;
    logic [15:0]     err_total_reg,  err_total_next;
    logic [15:0]     wrap_total_reg, wrap_total_next;

    // -------------------------------------------------------------------------
    // Expected next sample derived from the previous accepted sample.
    // Each field wraps at its own width, so modular roll-overs are matches.
    // -------------------------------------------------------------------------
    logic [CW-1:0] exp_c;
    logic [EW-1:0] exp_e;
    logic [OW-1:0] exp_o;

    assign exp_c = pc_reg + CW'(1);
    // even_count advances when the new count is even, odd_count when it is odd.
    assign exp_e = pe_reg + EW'(!exp_c[0]);
    assign exp_o = po_reg + OW'(exp_c[0]);

    // Zero-extend observed and expected fields to a common width so the
    // per-field comparators can be generated uniformly.
    logic [FW-1:0] obs_field [3];
    logic [FW-1:0] exp_field [3];
    logic [2:0]    field_mis;
    logic          sample_match;

    assign obs_field[0] = FW'(count);
    assign obs_field[1] = FW'(even_count);
    assign obs_field[2] = FW'(odd_count);
    assign exp_field[0] = FW'(exp_c);
    assign exp_field[1] = FW'(exp_e);
    assign exp_field[2] = FW'(exp_o);

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_field_cmp
            assign field_mis[gi] = (obs_field[gi] != exp_field[gi]);
        end
    endgenerate

    assign sample_match = (field_mis == 3'b000);

    // A wrap is only counted on a matching sample, so count==0 is implied by
    // the match once the previous count was at its maximum; checking it
    // explicitly keeps the intent obvious.
    logic wrap_hit;
    assign wrap_hit = (pc_reg == COUNT_MAX) && (count == '0);

    // Saturating 16-bit increment shared by both tallies.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // -------------------------------------------------------------------------
    // Next-state / next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        pe_next         = pe_reg;
        po_next         = po_reg;
        run_next        = run_reg;
        err_next        = 1'b0;
        err_field_next  = err_field_reg;
        err_total_next  = err_total_reg;
        wrap_total_next = wrap_total_reg;

        if (en) begin
            // Every qualified sample becomes the new reference, whether it is
            // accepted as part of the run or used as a fresh seed.
            pc_next = count;
            pe_next = even_count;
            po_next = odd_count;

            case (state_reg)
                ST_IDLE: begin
                    run_next   = '0;
                    state_next = ST_SEED;
                end

                ST_SEED: begin
                    if (sample_match) begin
                        run_next = run_reg + RW'(1);
                        if (run_reg + RW'(1) == RW'(LOCK_LEN)) begin
                            state_next = ST_CHECK;
                        end
                    end else begin
                        // Not locked yet: silently re-seed, no error report.
                        run_next = '0;
                    end
                end

                ST_CHECK: begin
                    if (sample_match) begin
                        if (wrap_hit) begin
                            wrap_total_next = sat_inc(wrap_total_reg);
                        end
                    end else begin
                        // Leaving CHECK on the first mismatch is what keeps
                        // err a single-cycle pulse for back-to-back errors.
                        err_next       = 1'b1;
                        err_field_next = field_mis;
                        err_total_next = sat_inc(err_total_reg);
                        run_next       = '0;
                        state_next     = ST_SEED;
                    end
                end

                default: begin
                    state_next = ST_IDLE;
                    run_next   = '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            pc_reg         <= '0;
            pe_reg         <= '0;
            po_reg         <= '0;
            run_reg        <= '0;
            err_reg        <= 1'b0;
            err_field_reg  <= 3'b000;
            err_total_reg  <= 16'd0;
            wrap_total_reg <= 16'd0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            pe_reg         <= pe_next;
            po_reg         <= po_next;
            run_reg        <= run_next;
            err_reg        <= err_next;
            err_field_reg  <= err_field_next;
            err_total_reg  <= err_total_next;
            wrap_total_reg <= wrap_total_next;
        end
    end

    // locked comes straight from the state register, so it is registered and
    // rises the cycle after the LOCK_LEN-th matching post-seed sample.
    assign locked     = (state_reg == ST_CHECK);
    assign err        = err_reg;
    assign err_field  = err_field_reg;
    assign err_total  = err_total_reg;
    assign wrap_total = wrap_total_reg;

endmodule
